// File: rtl/shared_data_bus_pkg.sv
// Shared types and constants for the shared data bus arbiter.
//   MAX_PORTS   : largest supported requester count
//   port_idx_t  : requester index, wide enough for MAX_PORTS
//   arb_state_t : lock FSM state (used when ARBITER_LOCK_EN is defined)
//   next_index  : round-robin successor of a port index
package shared_data_bus_pkg;

  localparam int unsigned MAX_PORTS  = 8;
  localparam int unsigned PORT_IDX_W = $clog2(MAX_PORTS);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // (idx + 1) mod num_ports
  function automatic port_idx_t next_index(input port_idx_t idx, input int unsigned num_ports);
    if (32'(idx) + 32'd1 >= num_ports) begin
      return '0;
    end
    return idx + port_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker.
// Ports:
//   req_i         : request vector
//   mask_i        : eligibility mask (all ones for plain round robin)
//   start_i       : index searched first; the search wraps modulo NUM_PORTS
//   grant_o       : one-hot grant, zero when nothing eligible
//   grant_idx_o   : index of the granted request
//   grant_valid_o : some request was granted
module rr_priority_picker
  import shared_data_bus_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] mask_i,
  input  port_idx_t            start_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output port_idx_t            grant_idx_o,
  output logic                 grant_valid_o
);

  logic [NUM_PORTS-1:0]   avail;
  logic [2*NUM_PORTS-1:0] rot;
  int unsigned            sum;

  always_comb begin
    avail         = req_i & mask_i;
    // Doubling the vector lets a plain shift implement the wrap-around search.
    rot           = {avail, avail} >> start_i;
    sum           = 0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    grant_o       = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!grant_valid_o && rot[i]) begin
        sum = 32'(start_i) + i;
        if (sum >= NUM_PORTS) begin
          sum = sum - NUM_PORTS;
        end
        grant_idx_o   = port_idx_t'(sum);
        grant_valid_o = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      grant_o[i] = grant_valid_o && (grant_idx_o == port_idx_t'(i));
    end
  end

endmodule

// File: rtl/shared_data_bus_arbiter.sv
// Round-robin arbiter letting NUM_PORTS requesters share one data memory bus.
// A granted port drives the bus in the same cycle; read data is registered and
// returned with a one-cycle rsp_valid pulse to the port that issued the read.
// Optional feature: define ARBITER_LOCK_EN to honour req_lock (bus locking for
// atomic sequences, released by an unlocking transfer or LOCK_TIMEOUT idle cycles).
// Ports:
//   clock, reset (async, active-low)
//   req_*       : per-port request buses, port i at slice [i*W +: W]
//   req_ready   : one-hot grant (combinational)
//   rsp_valid   : per-port read response pulse; rsp_read_data shared
//   bus_*       : memory side; bus_read_data is combinational from memory
module shared_data_bus_arbiter
  import shared_data_bus_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req_valid,
  output logic [NUM_PORTS-1:0]              req_ready,
  input  logic [NUM_PORTS-1:0]              req_write,
  input  logic [NUM_PORTS-1:0]              req_lock,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_write_data,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_byte_enable,
  output logic [NUM_PORTS-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]             rsp_read_data,
  output logic [ADDR_WIDTH-1:0]             bus_address,
  output logic [DATA_WIDTH-1:0]             bus_write_data,
  output logic [DATA_WIDTH/8-1:0]           bus_byte_enable,
  output logic                              bus_read_enable,
  output logic                              bus_write_enable,
  input  logic [DATA_WIDTH-1:0]             bus_read_data
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  port_idx_t             last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_read_data_q, rsp_read_data_d;

  port_idx_t            start_idx;
  logic [NUM_PORTS-1:0] pick_mask;
  logic [NUM_PORTS-1:0] pick_grant;
  port_idx_t            pick_idx;
  logic                 pick_valid;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_valid;
  logic                 grant_write;

  assign start_idx = next_index(last_grant_q, NUM_PORTS);

  rr_priority_picker #(
    .NUM_PORTS(NUM_PORTS)
  ) u_picker (
    .req_i        (req_valid),
    .mask_i       (pick_mask),
    .start_i      (start_idx),
    .grant_o      (pick_grant),
    .grant_idx_o  (pick_idx),
    .grant_valid_o(pick_valid)
  );

  // Nothing is granted while reset is held low.
  assign grant       = reset ? pick_grant : '0;
  assign grant_valid = reset & pick_valid;
  assign req_ready   = grant;

  always_comb begin
    bus_address     = '0;
    bus_write_data  = '0;
    bus_byte_enable = '0;
    grant_write     = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        bus_address     = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus_write_data  = req_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        bus_byte_enable = req_byte_enable[i*BE_WIDTH +: BE_WIDTH];
        grant_write     = req_write[i];
      end
    end
  end

  assign bus_read_enable  = grant_valid & ~grant_write;
  assign bus_write_enable = grant_valid & grant_write;

  always_comb begin
    last_grant_d    = grant_valid ? pick_idx : last_grant_q;
    rsp_valid_d     = '0;
    rsp_read_data_d = rsp_read_data_q;
    if (grant_valid && !grant_write) begin
      rsp_valid_d     = grant;
      rsp_read_data_d = bus_read_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q    <= port_idx_t'(NUM_PORTS - 1);
      rsp_valid_q     <= '0;
      rsp_read_data_q <= '0;
    end else begin
      last_grant_q    <= last_grant_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_read_data_q <= rsp_read_data_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_read_data = rsp_read_data_q;

`ifdef ARBITER_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  arb_state_t           state_q, state_d;
  port_idx_t            owner_q, owner_d;
  logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic [NUM_PORTS-1:0] owner_onehot;
  logic                 owner_valid;
  logic                 grant_lock;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      owner_onehot[i] = (owner_q == port_idx_t'(i));
    end
  end

  assign owner_valid = |(req_valid & owner_onehot);
  assign grant_lock  = |(grant & req_lock);
  assign pick_mask   = (state_q == ARB_LOCKED) ? owner_onehot : '1;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid && grant_lock) begin
          state_d    = ARB_LOCKED;
          owner_d    = pick_idx;
          idle_cnt_d = '0;
        end
      end
      ARB_LOCKED: begin
        // Only the owner can be granted here, so grant_valid means an owner transfer.
        if (grant_valid && !grant_lock) begin
          state_d    = ARB_IDLE;
          idle_cnt_d = '0;
        end else if (owner_valid) begin
          idle_cnt_d = '0;
        end else if (32'(idle_cnt_q) + 32'd1 >= LOCK_TIMEOUT) begin
          // This cycle is the LOCK_TIMEOUT-th idle one: free the bus from the next cycle.
          state_d    = ARB_IDLE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  // Pure round robin: req_lock and LOCK_TIMEOUT are intentionally ignored.
  localparam int unsigned unused_lock_timeout = LOCK_TIMEOUT;
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign pick_mask   = '1;
`endif

endmodule

// File: tb/tb_shared_data_bus_arbiter.sv
module tb_shared_data_bus_arbiter;

  localparam int NP = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int LT = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NP-1:0]     req_valid = '0;
  logic [NP-1:0]     req_ready;
  logic [NP-1:0]     req_write = '0;
  logic [NP-1:0]     req_lock = '0;
  logic [NP*AW-1:0]  req_address = '0;
  logic [NP*DW-1:0]  req_write_data = '0;
  logic [NP*BW-1:0]  req_byte_enable = '0;
  logic [NP-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_read_data;
  logic [AW-1:0]     bus_address;
  logic [DW-1:0]     bus_write_data;
  logic [BW-1:0]     bus_byte_enable;
  logic              bus_read_enable;
  logic              bus_write_enable;
  logic [DW-1:0]     bus_read_data;

  shared_data_bus_arbiter #(
    .NUM_PORTS   (NP),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_lock        (req_lock),
    .req_address     (req_address),
    .req_write_data  (req_write_data),
    .req_byte_enable (req_byte_enable),
    .rsp_valid       (rsp_valid),
    .rsp_read_data   (rsp_read_data),
    .bus_address     (bus_address),
    .bus_write_data  (bus_write_data),
    .bus_byte_enable (bus_byte_enable),
    .bus_read_enable (bus_read_enable),
    .bus_write_enable(bus_write_enable),
    .bus_read_data   (bus_read_data)
  );

  always #5 clock = ~clock;

  // Memory: read data is a fixed function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  assign bus_read_data = mem_fn(bus_address);

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_last;
  bit          m_locked;
  int          m_owner;
  int          m_idle;
  int          m_grant;
  logic [NP-1:0] m_rsp_v;
  logic [31:0] m_rsp_d;
  int          dut_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_addr(input int p);
    return req_address[p*AW +: AW];
  endfunction

  function automatic logic [31:0] get_wdata(input int p);
    return req_write_data[p*DW +: DW];
  endfunction

  function automatic logic [3:0] get_be(input int p);
    return req_byte_enable[p*BW +: BW];
  endfunction

  task automatic model_reset();
    m_last   = NP - 1;
    m_locked = 0;
    m_owner  = 0;
    m_idle   = 0;
    m_grant  = -1;
    m_rsp_v  = '0;
    m_rsp_d  = '0;
  endtask

  task automatic drive(input int p, input bit v, input bit w, input bit l,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid[p]                  = v;
    req_write[p]                  = w;
    req_lock[p]                   = l;
    req_address[p*AW +: AW]       = a;
    req_write_data[p*DW +: DW]    = d;
    req_byte_enable[p*BW +: BW]   = be;
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) drive(p, 0, 0, 0, '0, '0, '0);
  endtask

  // Called right after a falling edge once inputs are set: checks this cycle's
  // combinational outputs and last cycle's response, then advances the model.
  task automatic cycle();
    logic [NP-1:0] exp_ready;
    bit            g_write;
    #1;
    m_grant = -1;
    for (int off = 1; off <= NP; off++) begin
      int p;
      p = (m_last + off) % NP;
      if (m_grant < 0 && req_valid[p] && (!m_locked || p == m_owner)) m_grant = p;
    end
    dut_grant = -1;
    for (int i = 0; i < NP; i++) if (req_ready[i]) dut_grant = i;
    exp_ready = '0;
    if (m_grant >= 0) exp_ready[m_grant] = 1'b1;
    g_write = (m_grant >= 0) ? req_write[m_grant] : 1'b0;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("bus_address", bus_address, (m_grant >= 0) ? get_addr(m_grant) : 32'h0);
    check("bus_write_data", bus_write_data, (m_grant >= 0) ? get_wdata(m_grant) : 32'h0);
    check("bus_byte_enable", 32'(bus_byte_enable),
          (m_grant >= 0) ? 32'(get_be(m_grant)) : 32'h0);
    check("bus_read_enable", 32'(bus_read_enable), 32'(m_grant >= 0 && !g_write));
    check("bus_write_enable", 32'(bus_write_enable), 32'(m_grant >= 0 && g_write));
    check("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
    check("rsp_read_data", rsp_read_data, m_rsp_d);
    @(posedge clock);
    m_rsp_v = '0;
    if (m_grant >= 0 && !g_write) begin
      m_rsp_v[m_grant] = 1'b1;
      m_rsp_d          = mem_fn(get_addr(m_grant));
    end
`ifdef ARBITER_LOCK_EN
    if (!m_locked) begin
      if (m_grant >= 0 && req_lock[m_grant]) begin
        m_locked = 1;
        m_owner  = m_grant;
        m_idle   = 0;
      end
    end else if (m_grant >= 0 && !req_lock[m_grant]) begin
      m_locked = 0;
      m_idle   = 0;
    end else if (req_valid[m_owner]) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle >= LT) begin
        m_locked = 0;
        m_idle   = 0;
      end
    end
`endif
    if (m_grant >= 0) m_last = m_grant;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    // Reset held low: outputs forced to zero even with a pending request.
    @(negedge clock);
    drive(0, 1, 0, 0, 32'h10, 32'h0, 4'hF);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_bus_read_enable", 32'(bus_read_enable), 32'h0);
    check("rst_bus_address", bus_address, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_read_data", rsp_read_data, 32'h0);
    @(negedge clock);
    clear_all();
    reset = 1'b1;

    // Single port 1 write: granted in the same cycle, no response.
    drive(1, 1, 1, 0, 32'h40, 32'hDEADBEEF, 4'hF);
    cycle();
    check("wr_grant_port1", 32'(dut_grant), 32'd1);
    clear_all();
    cycle();
    check("wr_no_rsp", 32'(rsp_valid), 32'h0);

    // Ports 0 and 1 reading continuously: grants alternate 0,1,0,1,...
    drive(0, 1, 0, 0, 32'h100, 32'h0, 4'hF);
    drive(1, 1, 0, 0, 32'h200, 32'h0, 4'hF);
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("alt_grant", 32'(dut_grant), 32'(k % 2));
    end
    clear_all();
    cycle();

    // Lock: port 0 locked read, then unlocking write; port 1 waits throughout.
    drive(0, 1, 0, 1, 32'h80, 32'h0, 4'hF);
    drive(1, 1, 0, 0, 32'h200, 32'h0, 4'hF);
    cycle();
    check("lock_first", 32'(dut_grant), 32'd0);
    drive(0, 1, 1, 0, 32'h80, 32'h1111_2222, 4'hF);
    cycle();
`ifdef ARBITER_LOCK_EN
    check("lock_blocks_port1", 32'(dut_grant), 32'd0);
`else
    check("nolock_alternates", 32'(dut_grant), 32'd1);
`endif
    drive(0, 0, 0, 0, '0, '0, '0);
    cycle();
    check("lock_then_port1", 32'(dut_grant), 32'd1);
    clear_all();
    cycle();

    // Lock timeout: port 0 locks and goes quiet; port 1 keeps requesting.
    drive(0, 1, 0, 1, 32'h80, 32'h0, 4'hF);
    drive(1, 1, 0, 0, 32'h204, 32'h0, 4'hF);
    cycle();
    check("timeout_lock_grant", 32'(dut_grant), 32'd0);
    drive(0, 0, 0, 0, '0, '0, '0);
    n = 0;
    do begin
      cycle();
      n++;
    end while (dut_grant != 1 && n < 40);
`ifdef ARBITER_LOCK_EN
    check("timeout_cycles", 32'(n), 32'd17);
`else
    check("timeout_cycles", 32'(n), 32'd1);
`endif
    clear_all();
    cycle();

    // Random traffic; a waiting requester holds its fields.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!(req_valid[p] && m_grant != p)) begin
          drive(p, ($urandom % 3) != 0, $urandom % 2, ($urandom % 4) == 0,
                $urandom & 32'hFFFC, $urandom, 4'($urandom));
        end
      end
      cycle();
    end
    clear_all();
    cycle();

    // Reset in the middle of a port 1 read cancels the response.
    drive(1, 1, 0, 0, 32'h300, 32'h0, 4'hF);
    cycle();
    check("mid_read_grant", 32'(dut_grant), 32'd1);
    #1;
    check("mid_read_rsp", 32'(rsp_valid), 32'h2);
    reset = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_rsp_data", rsp_read_data, 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(0, 1, 0, 0, 32'h500, 32'h0, 4'hF);
    drive(1, 1, 0, 0, 32'h600, 32'h0, 4'hF);
    cycle();
    check("post_rst_port0_first", 32'(dut_grant), 32'd0);
    cycle();
    check("post_rst_port1_next", 32'(dut_grant), 32'd1);
    clear_all();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
